tone_bank: RTL

//   Parametrised bank of NUM_CH independent clock dividers / tone generators.

---
 rtl/tone_bank.sv | 62 ++++++
 1 files changed

// File: rtl/tone_bank.sv
// tone_bank: bank of NUM_CH independent programmable clock dividers.
// Each channel emits a reload tick plus a square or pulse-train output.
module tone_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int DEF_COUNT = 749,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave_out
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_COUNT);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             wave_q;
    logic             hit;

    // out-of-range channel numbers never match any channel
    assign hit = wr_en && (int'(wr_ch) == ch);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        per_q  <= DEF;
        cnt_q  <= DEF;
        tick_q <= 1'b0;
        wave_q <= 1'b0;
      end else if (hit) begin
        per_q  <= wr_data;
        cnt_q  <= wr_data;
        tick_q <= 1'b0;
        if (!mode[ch]) wave_q <= 1'b0;
      end else if (!en[ch]) begin
        cnt_q  <= per_q;
        tick_q <= 1'b0;
        wave_q <= 1'b0;
      end else if (cnt_q == '0) begin
        cnt_q  <= per_q;
        tick_q <= 1'b1;
        wave_q <= mode[ch] ? ~wave_q : 1'b1;
      end else begin
        cnt_q  <= cnt_q - 1'b1;
        tick_q <= 1'b0;
        if (!mode[ch]) wave_q <= 1'b0;
      end
    end

    assign tick[ch]     = tick_q;
    assign wave_out[ch] = wave_q;
  end

endmodule
